// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: data-cache request/response handshake, byte lanes, load extension.
// Optional macro LSU_MISALIGN_TRAP_EN: reject misaligned accesses instead of issuing them.
module mem_stage_lsu #(
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        load_valid,
   output logic [31:0] load_data,
   output logic        bus_err,
   output logic        misalign_err,
   output logic [31:0] dmem_address,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic [3:0]  dmem_mbe,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_resp
);
   localparam int CW = $clog2(TIMEOUT_CYC + 2) + 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ld_q, ld_d, abort_q, abort_d;
   logic [2:0]    f3_q, f3_d;
   logic [1:0]    off_q, off_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          dmem_read_q, dmem_read_d, dmem_write_q, dmem_write_d;
   logic [31:0]   dmem_address_q, dmem_address_d, dmem_wdata_q, dmem_wdata_d;
   logic [3:0]    dmem_mbe_q, dmem_mbe_d;

   logic          is_ld, is_st, legal, mis, present, accept;
   logic [3:0]    mbe_new;
   logic [31:0]   word;

   // A simultaneous read+write request is handled as a load.
   always_comb begin
      is_ld = mem_read;
      is_st = mem_write & ~mem_read;
      legal = 1'b0;
      if (is_ld)      legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      else if (is_st) legal = funct3 inside {3'b000, 3'b001, 3'b010};
      mis = ((funct3[1:0] == 2'b01) & addr[0]) | ((funct3[1:0] == 2'b10) & (|addr[1:0]));
      present = req_valid & legal;
`ifdef LSU_MISALIGN_TRAP_EN
      accept       = present & ~mis;
      misalign_err = (state_q == S_IDLE) & present & mis;
`else
      accept       = present;
      misalign_err = 1'b0;
`endif
      mbe_new = 4'b1111;
      if (is_st) begin
         case (funct3[1:0])
            2'b00:   mbe_new = 4'b0001 << addr[1:0];
            2'b01:   mbe_new = 4'b0011 << addr[1:0];
            default: mbe_new = 4'b1111 << addr[1:0];
         endcase
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      ld_d           = ld_q;
      abort_d        = abort_q;
      f3_d           = f3_q;
      off_d          = off_q;
      rdata_d        = rdata_q;
      dmem_read_d    = dmem_read_q;
      dmem_write_d   = dmem_write_q;
      dmem_address_d = dmem_address_q;
      dmem_wdata_d   = dmem_wdata_q;
      dmem_mbe_d     = dmem_mbe_q;
      stall          = 1'b0;
      load_valid     = 1'b0;
      bus_err        = 1'b0;
      load_data      = 32'h0;
      word           = rdata_q >> {off_q, 3'b000};
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               stall          = 1'b1;
               state_d        = S_BUSY;
               cnt_d          = '0;
               abort_d        = 1'b0;
               ld_d           = is_ld;
               f3_d           = funct3;
               off_d          = addr[1:0];
               dmem_read_d    = is_ld;
               dmem_write_d   = is_st;
               dmem_address_d = {addr[31:2], 2'b00};
               dmem_wdata_d   = wdata << {addr[1:0], 3'b000};
               dmem_mbe_d     = mbe_new;
            end
         end
         S_BUSY: begin
            stall = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (dmem_resp) begin
               rdata_d      = dmem_rdata;
               dmem_read_d  = 1'b0;
               dmem_write_d = 1'b0;
               cnt_d        = '0;
               state_d      = S_DONE;
            end else if ((TIMEOUT_CYC != 0) && (cnt_q + 1'b1 == CW'(TIMEOUT_CYC))) begin
               // Abort: zeroed capture makes the delivered load value 0.
               rdata_d      = 32'h0;
               abort_d      = 1'b1;
               dmem_read_d  = 1'b0;
               dmem_write_d = 1'b0;
               cnt_d        = '0;
               state_d      = S_DONE;
            end
         end
         S_DONE: begin
            state_d    = S_IDLE;
            load_valid = ld_q;
            bus_err    = abort_q;
            if (ld_q) begin
               case (f3_q)
                  3'b000:  load_data = {{24{word[7]}}, word[7:0]};
                  3'b001:  load_data = {{16{word[15]}}, word[15:0]};
                  3'b100:  load_data = {24'h0, word[7:0]};
                  3'b101:  load_data = {16'h0, word[15:0]};
                  default: load_data = word;
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         ld_q           <= 1'b0;
         abort_q        <= 1'b0;
         f3_q           <= 3'b000;
         off_q          <= 2'b00;
         rdata_q        <= 32'h0;
         dmem_read_q    <= 1'b0;
         dmem_write_q   <= 1'b0;
         dmem_address_q <= 32'h0;
         dmem_wdata_q   <= 32'h0;
         dmem_mbe_q     <= 4'h0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         ld_q           <= ld_d;
         abort_q        <= abort_d;
         f3_q           <= f3_d;
         off_q          <= off_d;
         rdata_q        <= rdata_d;
         dmem_read_q    <= dmem_read_d;
         dmem_write_q   <= dmem_write_d;
         dmem_address_q <= dmem_address_d;
         dmem_wdata_q   <= dmem_wdata_d;
         dmem_mbe_q     <= dmem_mbe_d;
      end
   end

   assign dmem_read    = dmem_read_q;
   assign dmem_write   = dmem_write_q;
   assign dmem_address = dmem_address_q;
   assign dmem_wdata   = dmem_wdata_q;
   assign dmem_mbe     = dmem_mbe_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed cases plus random transactions against an arithmetic model.
module tb_mem_stage_lsu;
   localparam int TO = 4;

   logic        clk = 1'b0, rst = 1'b0;
   logic        req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = 32'h0, wdata = 32'h0, dmem_rdata = 32'h0;
   logic        dmem_resp = 1'b0;
   logic        stall, load_valid, bus_err, misalign_err, dmem_read, dmem_write;
   logic [31:0] load_data, dmem_address, dmem_wdata;
   logic [3:0]  dmem_mbe;

   int n_cmp = 0, n_err = 0;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   mem_stage_lsu #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .load_valid(load_valid),
      .load_data(load_data), .bus_err(bus_err), .misalign_err(misalign_err),
      .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
      .dmem_mbe(dmem_mbe), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [2:0] f3);
      return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
      longint w, v, range;
      w = longint'(rd) / (longint'(1) << (8 * off));
      if (f3 == 3'b010) return w[31:0];
      range = longint'(1) << (8 * nbytes(f3));
      v = w % range;
      if (f3[2] == 1'b0 && v >= range / 2) v = v - range;
      return v[31:0];
   endfunction

   function automatic logic [3:0] model_mbe(input bit ld, input logic [2:0] f3, input int off);
      logic [3:0] m = 4'h0;
      if (ld) return 4'hF;
      for (int i = 0; i < 4; i++) if (i >= off && i < off + nbytes(f3)) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int off);
      longint v = (longint'(wd) * (longint'(1) << (8 * off))) % (longint'(1) << 32);
      return v[31:0];
   endfunction

   // One access: presented in IDLE, held through BUSY (inputs scrambled), then DONE and back to IDLE.
   task automatic txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int delay, input logic [31:0] rdat);
      bit ld, st, legal, mis, acc, timed_out, done;
      int off, k;
      ld = rd; st = wr && !rd; off = int'(a[1:0]);
      legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : st ? (f3 <= 3'd2) : 1'b0;
      mis = (off % nbytes(f3)) != 0;
      acc = legal && !(TRAP && mis);
      @(negedge clk);
      req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
      dmem_resp = 1'b0;
      #2;
      chk("idle_stall", stall, acc);
      chk("misalign_err", misalign_err, TRAP && legal && mis);
      if (!acc) begin
         @(posedge clk); #2;
         chk("noreq_read", dmem_read, 0);
         chk("noreq_write", dmem_write, 0);
         chk("noreq_stall", stall, 0);
         req_valid = 1'b0;
         return;
      end
      k = 0; done = 1'b0;
      while (!done) begin
         k++;
         @(negedge clk);
         addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
         dmem_resp = (k == delay);
         dmem_rdata = (k == delay) ? rdat : $urandom;
         #2;
         chk("busy_stall", stall, 1);
         chk("busy_read", dmem_read, ld);
         chk("busy_write", dmem_write, st);
         chk("busy_addr", dmem_address, {a[31:2], 2'b00});
         chk("busy_mbe", dmem_mbe, model_mbe(ld, f3, off));
         chk("busy_wdata", dmem_wdata, model_wdata(wd, off));
         chk("busy_lvalid", load_valid, 0);
         done = (k == delay) || (k == TO);
      end
      timed_out = delay > TO;
      @(negedge clk);
      dmem_resp = 1'b0; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b000;
      #2;
      chk("done_stall", stall, 0);
      chk("done_lvalid", load_valid, ld);
      chk("done_ldata", load_data, (ld && !timed_out) ? model_load(f3, off, rdat) : 32'h0);
      chk("done_buserr", bus_err, timed_out);
      chk("done_read", dmem_read, 0);
      chk("done_write", dmem_write, 0);
      chk("done_mis", misalign_err, 0);
      @(negedge clk);
      req_valid = 1'b0;
      #2;
      chk("after_read", dmem_read, 0);
      chk("after_lvalid", load_valid, 0);
      chk("after_stall", stall, 0);
   endtask

   initial begin
      #3;
      chk("rst_stall", stall, 0);
      chk("rst_lvalid", load_valid, 0);
      chk("rst_ldata", load_data, 0);
      chk("rst_buserr", bus_err, 0);
      chk("rst_mis", misalign_err, 0);
      chk("rst_addr", dmem_address, 0);
      chk("rst_read", dmem_read, 0);
      chk("rst_write", dmem_write, 0);
      chk("rst_mbe", dmem_mbe, 0);
      chk("rst_wdata", dmem_wdata, 0);
      @(negedge clk); rst = 1'b1;

      txn(1, 0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF);
      txn(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FFFF7F);
      txn(1, 0, 3'b100, 32'h103, 32'h0, 3, 32'h80FFFF7F);
      txn(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 1, 32'h0);
      txn(1, 0, 3'b010, 32'h200, 32'h0, 99, 32'h0);
      txn(0, 1, 3'b010, 32'h101, 32'hCAFEF00D, 2, 32'h0);
      txn(1, 0, 3'b011, 32'h100, 32'h0, 1, 32'h0);
      txn(0, 1, 3'b101, 32'h100, 32'h0, 1, 32'h0);
      txn(1, 1, 3'b101, 32'h322, 32'h55AA55AA, 2, 32'h8001_7FFF);

      // Reset mid-transaction: strobes drop at once and no completion follows.
      @(negedge clk);
      req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h40;
      @(negedge clk); #2;
      chk("pre_rst_read", dmem_read, 1);
      rst = 1'b0; req_valid = 1'b0;
      #1;
      chk("rst_busy_read", dmem_read, 0);
      chk("rst_busy_stall", stall, 0);
      @(negedge clk); rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #2;
         chk("post_rst_lvalid", load_valid, 0);
         chk("post_rst_read", dmem_read, 0);
      end

      for (int n = 0; n < 60; n++)
         txn(1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom,
             $urandom_range(1, TO + 2), $urandom);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
